// File: rtl/cpu_pkg.sv
// Shared constants, opcode/state enums and opcode decode helper for the 8-bit CPU.
package cpu_pkg;

  localparam int CPU_ADDR_W = 4;
  localparam int CPU_DATA_W = 8;

  localparam logic [3:0] OPC_PREFIX = 4'b0001;

  typedef enum logic [3:0] {
    OP_LD   = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_STO  = 4'd5,
    OP_HALT = 4'd6
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ADDR  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  // An opcode byte is legal only with the fixed prefix and an op in LD..HALT.
  function automatic logic opc_legal(input logic [7:0] b);
    return (b[7:4] == OPC_PREFIX) && (b[3:0] <= 4'd6);
  endfunction

endpackage

// File: rtl/cpu_alu8.sv
// Combinational ALU for the accumulator: LD/ADD/SUB/AND/OR with carry/borrow and zero.
module cpu_alu8
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_operand,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // Extra top bit of the widened sum/difference is the carry/unsigned borrow.
  always_comb begin
    w_sum    = {1'b0, i_acc} + {1'b0, i_operand};
    w_diff   = {1'b0, i_acc} - {1'b0, i_operand};
    o_result = i_acc;
    o_carry  = 1'b0;
    case (i_op)
      OP_LD:   o_result = i_operand;
      OP_ADD:  begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_SUB:  begin
        o_result = w_diff[DATA_W-1:0];
        o_carry  = w_diff[DATA_W];
      end
      OP_AND:  o_result = i_acc & i_operand;
      OP_OR:   o_result = i_acc | i_operand;
      default: begin
        o_result = i_acc;
        o_carry  = 1'b0;
      end
    endcase
    o_zero = (o_result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/fetch_exec_ctrl.sv
// Fetch/operand/execute sequencer for the 8-bit CPU; drives the 16x8 memory
// and holds pc, accumulator and flags.
module fetch_exec_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] mem_data_sto,
  output logic              mem_isto,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [3:0]        r_ir;
  logic [DATA_W-1:0] r_acc;
  logic              r_z;
  logic              r_c;
  logic              r_halted;
  logic              r_illegal;
  logic              r_isto;

  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_alu_zero;
  logic [ADDR_W-1:0] w_addr;

  cpu_alu8 #(.DATA_W(DATA_W)) u_alu (
    .i_op      (r_ir),
    .i_acc     (r_acc),
    .i_operand (mem_data),
    .o_result  (w_alu_result),
    .o_carry   (w_alu_carry),
    .o_zero    (w_alu_zero)
  );

  // Memory address: operand address during execute, program counter otherwise.
  always_comb begin
    case (r_state)
      S_EXEC:  w_addr = r_mar;
      default: w_addr = r_pc;
    endcase
  end

  // Main sequencer; the store strobe is armed in S_ADDR so it is low exactly in S_EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_mar     <= {ADDR_W{1'b0}};
      r_ir      <= 4'd0;
      r_acc     <= {DATA_W{1'b0}};
      r_z       <= 1'b1;
      r_c       <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_isto    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_isto <= 1'b1;
          if (run) r_state <= S_FETCH;
          else     r_state <= S_IDLE;
        end
        S_FETCH: begin
          r_isto <= 1'b1;
          r_ir   <= mem_data[3:0];
          r_pc   <= r_pc + PC_ONE;
          if (!opc_legal(mem_data[7:0])) begin
            r_illegal <= 1'b1;
            r_halted  <= 1'b1;
            r_state   <= S_HALT;
          end else if (mem_data[3:0] == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_mar   <= mem_data[ADDR_W-1:0];
          r_pc    <= r_pc + PC_ONE;
          r_isto  <= (r_ir == OP_STO) ? 1'b0 : 1'b1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_isto <= 1'b1;
          if (r_ir != OP_STO) begin
            r_acc <= w_alu_result;
            r_z   <= w_alu_zero;
            r_c   <= w_alu_carry;
          end else begin
            r_acc <= r_acc;
          end
          r_state <= S_FETCH;
        end
        S_HALT: begin
          r_isto   <= 1'b1;
          r_halted <= 1'b1;
          r_state  <= S_HALT;
        end
        default: begin
          r_isto  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr     = w_addr;
  assign mem_data_sto = r_acc;
  assign mem_isto     = r_isto;
  assign acc          = r_acc;
  assign pc           = r_pc;
  assign flag_z       = r_z;
  assign flag_c       = r_c;
  assign halted       = r_halted;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Directed bench for fetch_exec_ctrl: table of two-instruction ALU programs plus
// hand-written sequences for timing, store, wrap, illegal opcode and async reset.
module tb_fetch_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] mem_data_sto;
  logic       mem_isto;
  logic [7:0] acc;
  logic [3:0] pc;
  logic       flag_z, flag_c, halted, illegal;

  logic       rst_w_n = 1'b0;
  logic       run_w = 1'b0;
  logic [3:0] mem_addr_w;
  logic [7:0] mem_data_w;
  logic [7:0] mem_data_sto_w;
  logic       mem_isto_w;
  logic [7:0] acc_w;
  logic [3:0] pc_w;
  logic       flag_z_w, flag_c_w, halted_w, illegal_w;

  logic [7:0] mem    [16];
  logic [7:0] prog   [16];
  logic [7:0] mem_w  [16];
  logic [7:0] prog_w [16];
  logic       load_req = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_acc;
    logic       exp_z;
    logic       exp_c;
  } vec_t;

  vec_t vecs [10];

  fetch_exec_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_data_sto(mem_data_sto), .mem_isto(mem_isto), .acc(acc), .pc(pc),
    .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .illegal(illegal)
  );

  fetch_exec_ctrl #(.RESET_PC(4'hF)) u_dut_wrap (
    .clk(clk), .rst_n(rst_w_n), .run(run_w), .mem_addr(mem_addr_w), .mem_data(mem_data_w),
    .mem_data_sto(mem_data_sto_w), .mem_isto(mem_isto_w), .acc(acc_w), .pc(pc_w),
    .flag_z(flag_z_w), .flag_c(flag_c_w), .halted(halted_w), .illegal(illegal_w)
  );

  always #5 clk = ~clk;

  assign mem_data   = mem[mem_addr];
  assign mem_data_w = mem_w[mem_addr_w];

  // Memory models: bulk program load, otherwise write on a low store strobe.
  always @(posedge clk) begin
    if (load_req) begin
      mem   <= prog;
      mem_w <= prog_w;
    end else begin
      if (!mem_isto)   mem[mem_addr]     <= mem_data_sto;
      if (!mem_isto_w) mem_w[mem_addr_w] <= mem_data_sto_w;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  // Hold reset, load the program image, release with run still low.
  task automatic reset_and_load();
    rst_n = 1'b0;
    run   = 1'b0;
    step(1);
    load_req = 1'b1;
    step(1);
    load_req = 1'b0;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic run_to_halt(input string name, input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      step(1);
      n++;
    end
    chk({name, "_halt_reached"}, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{op: 4'd1, a: 8'h07, b: 8'hFC, exp_acc: 8'h03, exp_z: 1'b0, exp_c: 1'b1};
    vecs[1] = '{op: 4'd2, a: 8'h03, b: 8'h05, exp_acc: 8'hFE, exp_z: 1'b0, exp_c: 1'b1};
    vecs[2] = '{op: 4'd2, a: 8'h05, b: 8'h05, exp_acc: 8'h00, exp_z: 1'b1, exp_c: 1'b0};
    vecs[3] = '{op: 4'd3, a: 8'h3E, b: 8'h0F, exp_acc: 8'h0E, exp_z: 1'b0, exp_c: 1'b0};
    vecs[4] = '{op: 4'd4, a: 8'h0E, b: 8'hA0, exp_acc: 8'hAE, exp_z: 1'b0, exp_c: 1'b0};
    vecs[5] = '{op: 4'd1, a: 8'hFF, b: 8'h01, exp_acc: 8'h00, exp_z: 1'b1, exp_c: 1'b1};
    vecs[6] = '{op: 4'd2, a: 8'h00, b: 8'h01, exp_acc: 8'hFF, exp_z: 1'b0, exp_c: 1'b1};
    vecs[7] = '{op: 4'd3, a: 8'hF0, b: 8'h0F, exp_acc: 8'h00, exp_z: 1'b1, exp_c: 1'b0};
    vecs[8] = '{op: 4'd1, a: 8'h80, b: 8'h7F, exp_acc: 8'hFF, exp_z: 1'b0, exp_c: 1'b0};
    vecs[9] = '{op: 4'd0, a: 8'h33, b: 8'h00, exp_acc: 8'h00, exp_z: 1'b1, exp_c: 1'b0};

    for (int i = 0; i < 16; i++) prog_w[i] = 8'h00;
    prog_w[4'hF] = 8'h10;
    prog_w[4'h0] = 8'h03;
    prog_w[4'h1] = 8'h16;
    prog_w[4'h3] = 8'h11;
    clear_prog();

    // Reset values while rst_n is held low
    step(2);
    chk("rst_acc", {24'd0, acc}, 32'h00);
    chk("rst_pc", {28'd0, pc}, 32'h0);
    chk("rst_z", {31'd0, flag_z}, 32'd1);
    chk("rst_c", {31'd0, flag_c}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_isto", {31'd0, mem_isto}, 32'd1);
    chk("rst_addr", {28'd0, mem_addr}, 32'h0);
    chk("rst_sto_data", {24'd0, mem_data_sto}, 32'h00);
    chk("rst_wrap_pc", {28'd0, pc_w}, 32'hF);

    // Idle with run low for 5 cycles
    reset_and_load();
    step(5);
    chk("idle_pc", {28'd0, pc}, 32'h0);
    chk("idle_isto", {31'd0, mem_isto}, 32'd1);
    chk("idle_addr", {28'd0, mem_addr}, 32'h0);
    chk("idle_halted", {31'd0, halted}, 32'd0);

    // Basic sequence with cycle-exact timing
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h05; prog[2] = 8'h11; prog[3] = 8'h06; prog[4] = 8'h16;
    prog[5] = 8'h07; prog[6] = 8'hFC;
    reset_and_load();
    run = 1'b1;
    step(1);
    chk("basic_first_fetch_addr", {28'd0, mem_addr}, 32'h0);
    step(3);
    chk("basic_ld_acc", {24'd0, acc}, 32'h07);
    chk("basic_ld_z", {31'd0, flag_z}, 32'd0);
    step(3);
    chk("basic_add_acc", {24'd0, acc}, 32'h03);
    chk("basic_add_c", {31'd0, flag_c}, 32'd1);
    chk("basic_halted_c7", {31'd0, halted}, 32'd0);
    step(1);
    chk("basic_halted_c8", {31'd0, halted}, 32'd1);
    chk("basic_pc", {28'd0, pc}, 32'h5);
    step(3);
    chk("basic_halt_terminal_pc", {28'd0, pc}, 32'h5);
    chk("basic_halt_isto", {31'd0, mem_isto}, 32'd1);

    // Table: LD a; <op> b; HALT
    for (int v = 0; v < 10; v++) begin
      clear_prog();
      prog[0] = 8'h10; prog[1] = 8'h08;
      prog[2] = {4'b0001, vecs[v].op}; prog[3] = 8'h09;
      prog[4] = 8'h16;
      prog[8] = vecs[v].a; prog[9] = vecs[v].b;
      reset_and_load();
      run = 1'b1;
      run_to_halt($sformatf("vec%0d", v), 20);
      chk($sformatf("vec%0d_acc", v), {24'd0, acc}, {24'd0, vecs[v].exp_acc});
      chk($sformatf("vec%0d_z", v), {31'd0, flag_z}, {31'd0, vecs[v].exp_z});
      chk($sformatf("vec%0d_c", v), {31'd0, flag_c}, {31'd0, vecs[v].exp_c});
      chk($sformatf("vec%0d_pc", v), {28'd0, pc}, 32'h5);
    end

    // Store timing; operand upper nibble ignored (0xFD -> address D)
    clear_prog();
    prog[0] = 8'h10; prog[1] = 8'h0C; prog[2] = 8'h15; prog[3] = 8'hFD; prog[4] = 8'h16;
    prog[4'hC] = 8'h5A;
    reset_and_load();
    run = 1'b1;
    step(5);
    chk("sto_isto_before", {31'd0, mem_isto}, 32'd1);
    step(1);
    chk("sto_isto_low", {31'd0, mem_isto}, 32'd0);
    chk("sto_addr", {28'd0, mem_addr}, 32'hD);
    chk("sto_data", {24'd0, mem_data_sto}, 32'h5A);
    step(1);
    chk("sto_isto_after", {31'd0, mem_isto}, 32'd1);
    chk("sto_mem_written", {24'd0, mem[4'hD]}, 32'h5A);
    chk("sto_acc_kept", {24'd0, acc}, 32'h5A);
    chk("sto_z_kept", {31'd0, flag_z}, 32'd0);
    step(1);
    chk("sto_halted", {31'd0, halted}, 32'd1);

    // Async reset in the middle of the store cycle
    reset_and_load();
    run = 1'b1;
    step(6);
    chk("rsto_isto_low", {31'd0, mem_isto}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rsto_isto_async", {31'd0, mem_isto}, 32'd1);
    chk("rsto_pc", {28'd0, pc}, 32'h0);
    chk("rsto_acc", {24'd0, acc}, 32'h00);
    chk("rsto_addr", {28'd0, mem_addr}, 32'h0);
    run = 1'b0;
    step(2);
    chk("rsto_no_write", {24'd0, mem[4'hD]}, 32'h00);
    rst_n = 1'b1;
    step(3);
    chk("rsto_idle_pc", {28'd0, pc}, 32'h0);
    chk("rsto_idle_halted", {31'd0, halted}, 32'd0);

    // Illegal opcodes: bad prefix, op beyond HALT, all-zero byte
    for (int k = 0; k < 3; k++) begin
      logic [7:0] bad;
      bad = (k == 0) ? 8'h27 : ((k == 1) ? 8'h17 : 8'h00);
      clear_prog();
      prog[0] = 8'h10; prog[1] = 8'h08; prog[2] = bad; prog[8] = 8'h42;
      reset_and_load();
      run = 1'b1;
      step(4);
      chk($sformatf("ill%0d_pre_illegal", k), {31'd0, illegal}, 32'd0);
      chk($sformatf("ill%0d_pre_halted", k), {31'd0, halted}, 32'd0);
      step(1);
      chk($sformatf("ill%0d_illegal", k), {31'd0, illegal}, 32'd1);
      chk($sformatf("ill%0d_halted", k), {31'd0, halted}, 32'd1);
      chk($sformatf("ill%0d_acc", k), {24'd0, acc}, 32'h42);
      step(3);
      chk($sformatf("ill%0d_pc_frozen", k), {28'd0, pc}, 32'h3);
      chk($sformatf("ill%0d_sticky", k), {31'd0, illegal}, 32'd1);
    end

    // PC wrap: LD opcode at F takes its operand from 0
    rst_w_n = 1'b1;
    step(1);
    run_w = 1'b1;
    step(1);
    chk("wrap_fetch_addr", {28'd0, mem_addr_w}, 32'hF);
    step(1);
    chk("wrap_operand_addr", {28'd0, mem_addr_w}, 32'h0);
    step(2);
    chk("wrap_acc", {24'd0, acc_w}, 32'h11);
    chk("wrap_pc", {28'd0, pc_w}, 32'h1);
    step(1);
    chk("wrap_halted", {31'd0, halted_w}, 32'd1);
    chk("wrap_pc_after_halt", {28'd0, pc_w}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
